line_scan_seq: RTL
==================

Name: line_scan_seq

Overview:
Upstream address sequencer for the team's 5-to-32 line decoder (dec5to32): produces the 5-bit line address that the decoder expands to one-hot.
- On start, steps through every line whose bit is set in a 32-bit enable mask, in ascending index order.
- Holds each address for a programmable dwell time, with a qualifying valid strobe.
- Pulses scan_done once the pass completes.
Used for row/column scanning (LED matrix, keypad strobe) where the decoder output drives the lines.

Parameters:
DWELL_W, 8, width of the dwell count; each line is held for dwell+1 cycles.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a scan pass; sampled only in IDLE
stop  input  1  abort the current pass at the next edge
dwell  input  DWELL_W  hold count, latched on accepted start
enable_mask  input  32  lines to visit (bit i = line i), latched on accepted start
A  output  5  line address to decoder; 0 whenever line_valid=0
line_valid  output  1  A is a live scan address
busy  output  1  high in SCAN and DONE states
scan_done  output  1  one-cycle pulse at the end of a completed pass

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- rst_n low: state=IDLE, A=0, line_valid=0, busy=0, scan_done=0, mask_q=0, dwell_q=0, cnt=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN: start=1 and stop=0 at an edge, and enable_mask != 0.
  - Same edge: mask_q<=enable_mask, dwell_q<=dwell, cnt<=dwell.
  - Same edge: A<=lowest set index of enable_mask, line_valid<=1, busy<=1.
  - Latency start->first valid address: 1 cycle.
- IDLE -> DONE: start=1, stop=0, enable_mask==0. No line is visited; busy<=1; scan_done pulses in the DONE cycle.
- SCAN, cnt != 0: cnt decrements; A held.
- SCAN, cnt == 0:
  - If mask_q has a set bit with index > A: A<=lowest such index, cnt<=dwell_q, stay in SCAN. The next line is valid immediately, with no gap cycle.
  - Otherwise: go to DONE; A<=0, line_valid<=0.
- Each line is therefore valid for exactly dwell_q+1 consecutive cycles.
- DONE: scan_done=1 for exactly one cycle, busy=1; next edge -> IDLE, busy<=0, scan_done<=0.
- stop=1 in SCAN or DONE: next edge -> IDLE, A<=0, line_valid<=0, busy<=0, scan_done<=0. An aborted pass never pulses scan_done. stop has priority over every other transition.
- stop=1 and start=1 together in IDLE: stay in IDLE.
- start in SCAN/DONE: ignored. enable_mask/dwell changes mid-pass: ignored (latched copies are used).
- Boundaries:
  - dwell=0 gives a 1-cycle hold per line.
  - dwell=all ones gives 2^DWELL_W cycles.
  - Single-bit mask visits one line, then DONE.
  - Bit 31 set is the last line and must not wrap to index 0.
- Reset asserted mid-pass: all outputs go to reset values immediately (asynchronous).

Optional Feature:
LINE_SCAN_LOOP_EN
- Defined: at SCAN with cnt==0 and no higher set bit, wrap A<=lowest set index of mask_q, cnt<=dwell_q, and stay in SCAN.
  - scan_done is asserted for that one cycle, concurrently with line_valid=1. There is no DONE visit in a looping pass.
  - The loop runs until stop or reset.
  - Zero mask still goes IDLE -> DONE -> IDLE.
- Undefined: single-pass behaviour exactly as above.

Test Plan:
- Reset, then start with mask=32'h0000_0013, dwell=2 -> A=0,1,4 each held 3 cycles with line_valid=1; A=0/line_valid=0 plus one scan_done pulse the cycle after line 4 ends; busy high for 10 cycles total.
- mask=32'h8000_0001, dwell=0 -> A=0 for 1 cycle, A=31 for 1 cycle, then DONE; A never wraps to 0 while valid.
- mask=0, start -> no line_valid; busy=1 and scan_done=1 in the same single cycle; IDLE after.
- mask=32'hFFFF_FFFF, dwell=1; assert stop while A=5 -> next edge line_valid=0, A=0, busy=0, scan_done never pulses; new start accepted afterwards.
- start held high throughout the pass plus a mid-pass mask change to 32'h1 -> original mask order completes, no restart until the cycle after returning to IDLE; rst_n pulsed low mid-dwell clears all outputs asynchronously.
- LINE_SCAN_LOOP_EN defined, mask=32'h0000_0006, dwell=0 -> A=1,2,1,2,...; scan_done high together with each A=1 after the first pass; stop ends the loop.

Source files
------------

// File: rtl/line_scan_seq_if.sv
// Handshake/bus bundle between a scan controller and line_scan_seq.
// The master drives the scan requests; the slave (the sequencer) drives the line address and status.
interface line_scan_seq_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [DWELL_W-1:0] dwell;
    logic [31:0]        enable_mask;
    logic [4:0]         A;
    logic               line_valid;
    logic               busy;
    logic               scan_done;

    modport master (
        output start, stop, dwell, enable_mask,
        input  A, line_valid, busy, scan_done
    );

    modport slave (
        input  start, stop, dwell, enable_mask,
        output A, line_valid, busy, scan_done
    );
endinterface

// File: rtl/line_scan_seq.sv
// Line address sequencer for dec5to32: visits each enabled line in ascending order, dwell+1 cycles each.
// Define LINE_SCAN_LOOP_EN to wrap continuously (scan_done marks each wrap) instead of a single pass.
module line_scan_seq #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    line_scan_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state;
    logic [31:0]        mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [4:0]         a_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    // Result is {found, index}: lowest set bit of m at or above position lo.
    function automatic logic [5:0] lowest_from(input logic [31:0] m, input logic [5:0] lo);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!r[5] && m[i] && (i >= 32'(lo))) begin
                r = {1'b1, 5'(i)};
            end
        end
        return r;
    endfunction

    logic [5:0] first_in;
    logic [5:0] next_q;
`ifdef LINE_SCAN_LOOP_EN
    logic [5:0] first_q;
`endif

    always_comb begin
        first_in = lowest_from(bus.enable_mask, '0);
        // A+1 reaches 32 after line 31, so nothing is found and the scan never wraps to line 0
        next_q   = lowest_from(mask_q, {1'b0, a_q} + 6'd1);
`ifdef LINE_SCAN_LOOP_EN
        first_q  = lowest_from(mask_q, '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            dwell_q <= '0;
            cnt     <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    a_q     <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        mask_q  <= bus.enable_mask;
                        dwell_q <= bus.dwell;
                        cnt     <= bus.dwell;
                        busy_q  <= 1'b1;
                        if (first_in[5]) begin
                            state   <= SCAN;
                            a_q     <= first_in[4:0];
                            valid_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    done_q <= 1'b0;
                    if (bus.stop) begin
                        state   <= IDLE;
                        a_q     <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (next_q[5]) begin
                        a_q <= next_q[4:0];
                        cnt <= dwell_q;
                    end else begin
`ifdef LINE_SCAN_LOOP_EN
                        a_q     <= first_q[4:0];
                        valid_q <= first_q[5];
                        cnt     <= dwell_q;
                        done_q  <= 1'b1;
`else
                        state   <= DONE;
                        a_q     <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    a_q     <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A          = a_q;
    assign bus.line_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.scan_done  = done_q;
endmodule
